// File: rtl/difftest_step_pkg.sv
// Shared types and widths for the difftest step gate.
// The queue entry pairs the cycle timestamp with the commit-step count.
package difftest_step_pkg;

    localparam int STEP_WIDTH_DEF = 8;
    localparam int CYC_WIDTH_DEF  = 32;
    localparam int DEPTH_DEF      = 16;

    typedef struct packed {
        logic [CYC_WIDTH_DEF-1:0]  cycle;
        logic [STEP_WIDTH_DEF-1:0] step;
    } step_entry_t;

    // One extra bit so the counter can represent a completely drained queue.
    function automatic int outstanding_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int OUTSTANDING_WIDTH_DEF = outstanding_width(DEPTH_DEF);

endpackage

// File: rtl/difftest_step_fifo.sv
// Synchronous FIFO of step entries; a write is visible at the head one cycle later.
// Pointers carry a wrap bit so full/empty come from a plain pointer compare.
module difftest_step_fifo
    import difftest_step_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        push,
    input  step_entry_t push_entry,
    input  logic        pop,
    output logic        full,
    output logic        empty,
    output step_entry_t head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    step_entry_t mem [DEPTH];

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_entry;
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/difftest_step_gate.sv
// Queues timestamped non-zero commit steps for a host checker and tracks its answers.
// Raises a sticky failure on a failed check, a lost step or a response with nothing outstanding.
module difftest_step_gate
    import difftest_step_pkg::*;
#(
    parameter int STEP_WIDTH = STEP_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int CYC_WIDTH  = CYC_WIDTH_DEF
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [STEP_WIDTH-1:0]   step,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [STEP_WIDTH-1:0]   out_step,
    output logic [CYC_WIDTH-1:0]    out_cycle,
    input  logic                    resp_valid,
    input  logic                    resp_fail,
    output logic                    simv_result,
    output logic                    overflow,
    output logic [$clog2(DEPTH):0]  outstanding
);

    localparam int OW = outstanding_width(DEPTH);
    localparam logic [OW-1:0] OUT_MAX = '1;

    logic [CYC_WIDTH-1:0] cycle_cnt;
    logic                 fifo_full;
    logic                 fifo_empty;
    step_entry_t          head;
    step_entry_t          push_entry;
    logic                 step_vld;
    logic                 pop;
    logic                 push;
    logic                 drop;
    logic                 resp_err;
    logic [OW-1:0]        outstanding_nxt;

    assign step_vld = (step != '0);
    assign pop      = out_valid && out_ready;
    // A full queue still accepts a step when the head leaves in the same cycle.
    assign push     = step_vld && (!fifo_full || pop);
    assign drop     = step_vld && fifo_full && !pop;

    assign push_entry.cycle = cycle_cnt;
    assign push_entry.step  = step;

    difftest_step_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .head       (head)
    );

    assign out_valid = !fifo_empty;
    assign out_step  = out_valid ? head.step  : '0;
    assign out_cycle = out_valid ? head.cycle : '0;

    always_comb begin
        outstanding_nxt = outstanding;
        resp_err        = 1'b0;
        if (pop && !resp_valid) begin
            // Saturate rather than wrap if the host stops answering.
            if (outstanding != OUT_MAX) outstanding_nxt = outstanding + 1'b1;
        end else if (!pop && resp_valid) begin
            if (outstanding == '0) resp_err = 1'b1;
            else                   outstanding_nxt = outstanding - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cycle_cnt   <= '0;
            outstanding <= '0;
            overflow    <= 1'b0;
            simv_result <= 1'b0;
        end else begin
            cycle_cnt   <= cycle_cnt + 1'b1;
            outstanding <= outstanding_nxt;
            if (drop) overflow <= 1'b1;
            if (drop || resp_err || (resp_valid && resp_fail)) simv_result <= 1'b1;
        end
    end

endmodule

// File: tb/tb_difftest_step_gate.sv
// Randomized and directed bench for difftest_step_gate against a queue-based reference model.
module tb_difftest_step_gate;

    localparam int DEPTH = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  step;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_step;
    logic [31:0] out_cycle;
    logic        resp_valid;
    logic        resp_fail;
    logic        simv_result;
    logic        overflow;
    logic [4:0]  outstanding;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] cyc;
        logic [7:0]  stp;
    } ent_t;

    ent_t        mq[$];
    int          m_out = 0;
    bit          m_res = 0;
    bit          m_ovf = 0;
    logic [31:0] m_cyc = '0;

    always #5 clock = ~clock;

    difftest_step_gate #(
        .STEP_WIDTH (8),
        .DEPTH      (DEPTH),
        .CYC_WIDTH  (32)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .step        (step),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_step    (out_step),
        .out_cycle   (out_cycle),
        .resp_valid  (resp_valid),
        .resp_fail   (resp_fail),
        .simv_result (simv_result),
        .overflow    (overflow),
        .outstanding (outstanding)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic [7:0] s, input logic rdy,
                         input logic rv, input logic rf);
        reset      = rst;
        step       = s;
        out_ready  = rdy;
        resp_valid = rv;
        resp_fail  = rf;
    endtask

    // Next model state from the cycle's rules: pops see the old queue, then pushes.
    task automatic model_update();
        int sz;
        bit do_pop;
        ent_t e;
        if (!reset) begin
            mq.delete();
            m_out = 0;
            m_res = 0;
            m_ovf = 0;
            m_cyc = '0;
            return;
        end
        sz     = mq.size();
        do_pop = (sz > 0) && out_ready;
        if (do_pop) void'(mq.pop_front());
        if (step != 0) begin
            if (sz < DEPTH || do_pop) begin
                e.cyc = m_cyc;
                e.stp = step;
                mq.push_back(e);
            end else begin
                m_ovf = 1;
                m_res = 1;
            end
        end
        if (resp_valid && m_out == 0 && !do_pop) m_res = 1;
        else m_out = m_out + int'(do_pop) - int'(resp_valid);
        if (resp_valid && resp_fail) m_res = 1;
        m_cyc = m_cyc + 1;
    endtask

    task automatic compare_all();
        bit v;
        v = mq.size() > 0;
        check_val("out_valid", out_valid, v);
        check_val("out_step", out_step, v ? mq[0].stp : 8'd0);
        check_val("out_cycle", out_cycle, v ? mq[0].cyc : 32'd0);
        check_val("simv_result", simv_result, m_res);
        check_val("overflow", overflow, m_ovf);
        check_val("outstanding", outstanding, m_out);
    endtask

    task automatic tick();
        model_update();
        @(posedge clock);
        @(negedge clock);
        compare_all();
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0);
        repeat (2) tick();
        drive(1, 0, 0, 0, 0);
    endtask

    initial begin
        int rdy_pct;
        logic [7:0] s;
        logic rv, rf, rdy, rst;

        // Reset values
        do_reset();
        check_val("rst_valid", out_valid, 1'b0);
        check_val("rst_outstanding", outstanding, 5'd0);
        check_val("rst_simv", simv_result, 1'b0);

        // Single step at cycle 5, drained and answered with a pass
        while (m_cyc != 5) tick();
        drive(1, 3, 1, 0, 0);
        tick();
        drive(1, 0, 1, 0, 0);
        check_val("p1_valid", out_valid, 1'b1);
        check_val("p1_step", out_step, 8'd3);
        check_val("p1_cycle", out_cycle, 32'd5);
        tick();
        check_val("p1_outstanding", outstanding, 5'd1);
        drive(1, 0, 0, 1, 0);
        tick();
        drive(1, 0, 0, 0, 0);
        check_val("p1_out_zero", outstanding, 5'd0);
        check_val("p1_simv", simv_result, 1'b0);

        // 1,2,0,4 with host stalled, then drain in order
        drive(1, 1, 0, 0, 0); tick();
        drive(1, 2, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 0); tick();
        drive(1, 4, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 0); tick();
        check_val("p2_depth", mq.size(), 3);
        check_val("p2_head", out_step, 8'd1);
        drive(1, 0, 1, 0, 0);
        repeat (4) tick();
        check_val("p2_drained", out_valid, 1'b0);
        drive(1, 0, 0, 1, 0); repeat (3) tick();

        // Overflow on the 17th push into a full queue
        do_reset();
        for (int i = 0; i < 17; i++) begin
            drive(1, 8'(i + 1), 0, 0, 0);
            tick();
            if (i == 15) check_val("p3_no_ovf_yet", overflow, 1'b0);
        end
        drive(1, 0, 0, 0, 0);
        check_val("p3_overflow", overflow, 1'b1);
        check_val("p3_simv", simv_result, 1'b1);
        // Simultaneous push and pop on a full queue loses nothing
        drive(1, 8'd99, 1, 0, 0); tick();
        drive(1, 0, 1, 0, 0);
        repeat (18) tick();

        // Failed response is sticky through 100 idle cycles
        do_reset();
        drive(1, 7, 1, 0, 0); tick();
        drive(1, 0, 1, 0, 0); tick();
        drive(1, 0, 0, 1, 1); tick();
        drive(1, 0, 0, 0, 0);
        check_val("p4_simv", simv_result, 1'b1);
        repeat (100) tick();
        check_val("p4_sticky", simv_result, 1'b1);

        // Response with nothing outstanding
        do_reset();
        drive(1, 0, 0, 1, 0); tick();
        drive(1, 0, 0, 0, 0);
        check_val("p5_simv", simv_result, 1'b1);
        check_val("p5_outstanding", outstanding, 5'd0);

        // Mid-operation reset discards everything and restarts the counter
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1, 8'(10 + i), 0, 0, 0);
            tick();
        end
        drive(1, 0, 0, 1, 0); tick();
        drive(0, 0, 0, 0, 0); tick();
        check_val("p6_valid", out_valid, 1'b0);
        check_val("p6_simv", simv_result, 1'b0);
        check_val("p6_overflow", overflow, 1'b0);
        drive(1, 5, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 0);
        check_val("p6_cycle0", out_cycle, 32'd0);

        // Randomized traffic with varying host readiness
        rdy_pct = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) rdy_pct = $urandom_range(0, 100);
            s   = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 255)) : 8'd0;
            rdy = (m_out < 20) && ($urandom_range(0, 99) < rdy_pct);
            rv  = (m_out > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 199) == 0);
            rf  = rv && ($urandom_range(0, 99) == 0);
            rst = ($urandom_range(0, 399) != 0);
            drive(rst, s, rdy, rv, rf);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
